// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: TX sequencer states and frame-level constants.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        IFG
    } fcs_state_t;

    localparam int          ETH_MIN_FRAME = 60;
    localparam int          ETH_FCS_BYTES = 4;
    localparam int          ETH_IFG_BYTES = 12;
    localparam logic [31:0] ETH_CRC_POLY  = 32'h04C11DB7;

endpackage

// File: rtl/eth_tx_fcs_ctrl.sv
// TX frame sequencer: forwards payload, pads short frames, appends FCS from the
// external CRC engine (LSB first), then holds off the next frame for the IFG.
module eth_tx_fcs_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = ETH_MIN_FRAME,
    parameter bit PAD_EN     = 1'b1,
    parameter int IFG_CYCLES = ETH_IFG_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        crc_init,
    output logic        crc_update,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_value
);

    localparam int CNT_W = 11;
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);

    fcs_state_t       state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;

    logic [CNT_W:0]   cnt_plus1;
    logic [CNT_W-1:0] cnt_sat_inc;
    logic             pad_needed;

    // One extra bit so the saturated count compares as 2048 and never pads.
    assign cnt_plus1   = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat_inc = (byte_cnt_q == {CNT_W{1'b1}}) ? byte_cnt_q : cnt_plus1[CNT_W-1:0];
    assign pad_needed  = PAD_EN && (cnt_plus1 < (CNT_W+1)'(MIN_FRAME));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            idx_q      <= '0;
            ifg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            ifg_cnt_q  <= ifg_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        ifg_cnt_d  = ifg_cnt_q;
        s_ready    = 1'b0;
        m_data     = 8'h00;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        crc_init   = 1'b0;
        crc_update = 1'b0;
        crc_data   = 8'h00;

        unique case (state_q)
            IDLE: begin
                crc_init   = 1'b1;
                byte_cnt_d = '0;
                idx_d      = '0;
                if (s_valid) state_d = DATA;
            end
            DATA: begin
                s_ready    = m_ready;
                m_data     = s_data;
                m_valid    = s_valid;
                crc_update = s_valid && m_ready;
                crc_data   = crc_update ? s_data : 8'h00;
                if (s_valid && m_ready) begin
                    byte_cnt_d = cnt_sat_inc;
                    if (s_last) state_d = pad_needed ? PAD : FCS;
                end
            end
            PAD: begin
                m_valid    = 1'b1;
                crc_update = m_ready;
                if (m_ready) begin
                    byte_cnt_d = cnt_sat_inc;
                    if (cnt_plus1 == (CNT_W+1)'(MIN_FRAME)) state_d = FCS;
                end
            end
            FCS: begin
                // crc_value is frozen here: no updates are issued in this state.
                m_valid = 1'b1;
                m_data  = crc_value[{idx_q, 3'b000} +: 8];
                m_last  = (idx_q == 2'(ETH_FCS_BYTES - 1));
                if (m_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (m_last) begin
                        state_d   = IFG;
                        ifg_cnt_d = '0;
                    end
                end
            end
            IFG: begin
                crc_init = 1'b1;
                if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) state_d = IDLE;
                else ifg_cnt_d = ifg_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Scoreboard bench: two sequencers (no-pad / pad) each beside a behavioural CRC-32 engine.
module tb_eth_tx_fcs_ctrl;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    typedef logic [7:0] bq_t [$];

    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic [7:0]  s_data     [2];
    logic        s_valid    [2];
    logic        s_last     [2];
    logic        s_ready    [2];
    logic [7:0]  m_data     [2];
    logic        m_valid    [2];
    logic        m_last     [2];
    logic        m_ready    [2] = '{1'b1, 1'b1};
    logic        crc_init   [2];
    logic        crc_update [2];
    logic [7:0]  crc_data   [2];
    logic [31:0] crc_acc    [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] crc_value  [2];
    bit          rnd_mode   [2] = '{1'b0, 1'b0};

    int nvec = 0;
    int nerr = 0;

    exp_t       exp_q  [2][$];
    logic       hold_v [2] = '{1'b0, 1'b0};
    logic [7:0] hold_d [2];

    eth_tx_fcs_ctrl #(.MIN_FRAME(60), .PAD_EN(1'b0), .IFG_CYCLES(12)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]), .m_ready(m_ready[0]),
        .crc_init(crc_init[0]), .crc_update(crc_update[0]), .crc_data(crc_data[0]),
        .crc_value(crc_value[0])
    );

    eth_tx_fcs_ctrl #(.MIN_FRAME(60), .PAD_EN(1'b1), .IFG_CYCLES(12)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]), .m_ready(m_ready[1]),
        .crc_init(crc_init[1]), .crc_update(crc_update[1]), .crc_data(crc_data[1]),
        .crc_value(crc_value[1])
    );

    // Reflected CRC-32 (poly 0x04C11DB7 bit-reversed), one byte per call.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // External engine: registered accumulator, finalized (inverted) value out.
    assign crc_value[0] = ~crc_acc[0];
    assign crc_value[1] = ~crc_acc[1];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (crc_init[u] === 1'b1) crc_acc[u] <= 32'hFFFF_FFFF;
            else if (crc_update[u] === 1'b1) crc_acc[u] <= crc_step(crc_acc[u], crc_data[u]);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) m_ready[u] = rnd_mode[u] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        nerr++;
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected stream on every downstream transfer.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n[u] !== 1'b1) begin
                hold_v[u] = 1'b0;
            end else begin
                if (hold_v[u] && m_valid[u]) chk($sformatf("hold_u%0d", u), {24'h0, m_data[u]}, {24'h0, hold_d[u]});
                hold_v[u] = m_valid[u] && !m_ready[u];
                hold_d[u] = m_data[u];
                if (crc_update[u] === 1'b0 && crc_data[u] !== 8'h00)
                    fail($sformatf("crc_data_idle_u%0d", u), {24'h0, crc_data[u]}, 32'h0);
                if (m_valid[u] && m_ready[u]) begin
                    if (exp_q[u].size() == 0) begin
                        fail($sformatf("unexpected_xfer_u%0d", u), {23'h0, m_last[u], m_data[u]}, 32'h0);
                    end else begin
                        exp_t e;
                        e = exp_q[u].pop_front();
                        chk($sformatf("stream_u%0d_rem%0d", u, exp_q[u].size()),
                            {23'h0, m_last[u], m_data[u]}, {23'h0, e.l, e.d});
                    end
                end
            end
        end
    end

    task automatic push_frame(input int u, input bq_t pl, input bit pad, input int keep);
        bq_t         st;
        logic [31:0] c;
        exp_t        e;
        st = pl;
        if (pad) while (st.size() < 60) st.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (st[i]) c = crc_step(c, st[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) st.push_back(c[8*i +: 8]);
        foreach (st[i]) begin
            if (i < keep) begin
                e.d = st[i];
                e.l = (i == st.size() - 1);
                exp_q[u].push_back(e);
            end
        end
    endtask

    task automatic send_frame(input int u, input bq_t pl);
        int guard;
        foreach (pl[i]) begin
            @(posedge clk); #1;
            s_data[u]  = pl[i];
            s_valid[u] = 1'b1;
            s_last[u]  = (i == pl.size() - 1);
            guard = 0;
            forever begin
                @(negedge clk);
                if (s_ready[u]) break;
                guard++;
                if (guard > 2000) begin
                    fail($sformatf("s_ready_timeout_u%0d", u), 32'h0, 32'h1);
                    break;
                end
            end
        end
    endtask

    task automatic idle_in(input int u);
        @(posedge clk); #1;
        s_valid[u] = 1'b0;
        s_last[u]  = 1'b0;
        s_data[u]  = 8'h00;
    endtask

    task automatic drain(input int u, input int budget);
        int n;
        n = 0;
        while (exp_q[u].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[u].size() != 0) fail($sformatf("drain_u%0d", u), exp_q[u].size(), 32'h0);
    endtask

    task automatic check_reset(input int u, input string tag);
        chk({tag, "_s_ready"},    {31'h0, s_ready[u]},    32'h0);
        chk({tag, "_m_valid"},    {31'h0, m_valid[u]},    32'h0);
        chk({tag, "_m_last"},     {31'h0, m_last[u]},     32'h0);
        chk({tag, "_m_data"},     {24'h0, m_data[u]},     32'h0);
        chk({tag, "_crc_update"}, {31'h0, crc_update[u]}, 32'h0);
        chk({tag, "_crc_data"},   {24'h0, crc_data[u]},   32'h0);
        chk({tag, "_crc_init"},   {31'h0, crc_init[u]},   32'h1);
    endtask

    // Counts cycles with s_ready low after the next m_last transfer.
    task automatic measure_gap(input int u);
        int n;
        int cnt;
        bit init_ok;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid[u] && m_ready[u] && m_last[u]) && n < 500);
        if (n >= 500) begin
            fail("gap_wait_m_last", 32'h0, 32'h1);
        end else begin
            cnt = 0;
            init_ok = 1'b1;
            forever begin
                @(negedge clk);
                if (s_ready[u]) break;
                cnt++;
                if (crc_init[u] !== 1'b1) init_ok = 1'b0;
                if (cnt > 100) break;
            end
            chk("ifg_s_ready_low_cycles", cnt, 32'd13);
            chk("ifg_crc_init_high", {31'h0, init_ok}, 32'h1);
        end
    endtask

    initial begin
        bq_t  pl;
        bq_t  pb;
        exp_t e;
        int   n;
        for (int u = 0; u < 2; u++) begin
            rst_n[u]   = 1'b0;
            s_valid[u] = 1'b0;
            s_last[u]  = 1'b0;
            s_data[u]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset(0, "reset_u0");
        check_reset(1, "reset_u1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // "123456789" without padding: well-known CRC 0xCBF43926, sent LSB first.
        pl = {};
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        foreach (pl[i]) begin
            e.d = pl[i]; e.l = 1'b0; exp_q[0].push_back(e);
        end
        e.d = 8'h26; e.l = 1'b0; exp_q[0].push_back(e);
        e.d = 8'h39; e.l = 1'b0; exp_q[0].push_back(e);
        e.d = 8'hF4; e.l = 1'b0; exp_q[0].push_back(e);
        e.d = 8'hCB; e.l = 1'b1; exp_q[0].push_back(e);
        send_frame(0, pl);
        idle_in(0);
        drain(0, 200);

        // Single byte padded to 60, then FCS: 64 transfers.
        pl = {8'hAB};
        push_frame(1, pl, 1'b1, BIG);
        chk("pad_frame_len", exp_q[1].size(), 32'd64);
        send_frame(1, pl);
        idle_in(1);
        drain(1, 300);

        // Exactly MIN_FRAME bytes: FCS follows byte 60 directly.
        pl = {};
        for (int i = 0; i < 60; i++) pl.push_back(8'(i + 1));
        push_frame(1, pl, 1'b1, BIG);
        send_frame(1, pl);
        idle_in(1);
        drain(1, 300);

        // 64-byte frame under random back-pressure.
        pl = {};
        for (int i = 0; i < 64; i++) pl.push_back(8'(i * 7 + 3));
        push_frame(1, pl, 1'b1, BIG);
        rnd_mode[1] = 1'b1;
        send_frame(1, pl);
        idle_in(1);
        drain(1, 1000);
        rnd_mode[1] = 1'b0;

        // Back-to-back frames with s_valid held high across the gap.
        pl = {};
        for (int i = 0; i < 10; i++) pl.push_back(8'hC0 + 8'(i));
        pb = {8'h5A, 8'hA5, 8'h3C};
        push_frame(1, pl, 1'b1, BIG);
        push_frame(1, pb, 1'b1, BIG);
        send_frame(1, pl);
        fork
            send_frame(1, pb);
            measure_gap(1);
        join
        idle_in(1);
        drain(1, 400);

        // Abort during FCS byte 2: only data plus FCS bytes 0..1 are expected.
        pl = {};
        for (int i = 0; i < 60; i++) pl.push_back(8'hFF - 8'(i));
        push_frame(1, pl, 1'b1, 62);
        send_frame(1, pl);
        idle_in(1);
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (exp_q[1].size() == 0) break;
            n++;
            if (n > 300) begin
                fail("abort_wait", exp_q[1].size(), 32'h0);
                break;
            end
        end
        @(posedge clk); #1;
        chk("abort_at_fcs_idx2", {24'h0, m_data[1]}, {24'h0, crc_value[1][23:16]});
        rst_n[1] = 1'b0;
        #1;
        check_reset(1, "async_reset_u1");
        repeat (3) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;

        pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        push_frame(1, pl, 1'b1, BIG);
        send_frame(1, pl);
        idle_in(1);
        drain(1, 300);

        repeat (20) @(posedge clk);
        drain(0, 10);
        drain(1, 10);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
